alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WORDSIZE, default 16, data width of the ALU bus and operands.
REQ-002 SHALL have parameter CACHE_EN, default 1, which enables skipping reloads of unchanged A/B/op.
REQ-003 SHALL have port i_Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_Reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_ReqValid  input  1  an operation request is present.
REQ-006 SHALL have port o_ReqReady  output  1  the sequencer accepts a request this cycle.
REQ-007 SHALL have port i_ReqA  input  WORDSIZE  operand A.
REQ-008 SHALL have port i_ReqB  input  WORDSIZE  operand B.
REQ-009 SHALL have port i_ReqOp  input  4  ALU opcode.
REQ-010 SHALL have port i_ReqUseF  input  1  the request loads flags before compute.
REQ-011 SHALL have port i_ReqF  input  WORDSIZE  flags value to load when i_ReqUseF=1.
REQ-012 SHALL have port o_RspValid  output  1  result is valid.
REQ-013 SHALL have port i_RspReady  input  1  the consumer takes the result.
REQ-014 SHALL have port o_RspY  output  WORDSIZE  the result word.
REQ-015 SHALL have port o_RspF  output  WORDSIZE  the result flags.
REQ-016 SHALL have port o_RspErr  output  1  the ALU failed to assert o_valid during a readback.
REQ-017 SHALL have port o_Command  output  command width of constants_pkg  the command to the ALU bus.
REQ-018 SHALL have port o_BusData  output  WORDSIZE  drives the ALU i_data.
REQ-019 SHALL have port o_BusValid  output  1  drives the ALU i_valid.
REQ-020 SHALL have port i_BusData  input  WORDSIZE  receives the ALU o_data.
REQ-021 SHALL have port i_BusValid  input  1  receives the ALU o_valid.

Function
REQ-022 SHALL implement FSM states IDLE, LD_A, LD_B, LD_OP, LD_F, COMPUTE, RD_Y, RD_F, RESP, one cycle each except IDLE and RESP.
REQ-023 SHALL drive o_ReqReady=1 only in IDLE; accept on i_ReqValid & o_ReqReady and register A, B, Op, UseF and F.
REQ-024 SHALL on accept go to LD_A; next-state order LD_A→LD_B→LD_OP→LD_F (only if UseF)→COMPUTE→RD_Y→RD_F→RESP.
REQ-025 SHALL in LD_A, LD_B, LD_OP, LD_F drive COM_LATCHA, COM_LATCHB, COM_LATCHOP, COM_LATCHF respectively, with o_BusValid=1 and o_BusData = A, B, {zero-extended Op}, F.
REQ-026 SHALL in COMPUTE drive COM_COMPUTE with o_BusValid=0.
REQ-027 SHALL in RD_Y and RD_F drive COM_OUTPUTY and COM_OUTPUTF with o_BusValid=0, and capture i_BusData into the Y/F result registers.
REQ-028 SHALL in IDLE and RESP drive COM_NOP, o_BusValid=0, o_BusData=0.
REQ-029 SHALL, if i_BusValid=0 in RD_Y or RD_F, capture 0 for that word and set o_RspErr=1 for this response.
REQ-030 SHALL in RESP hold o_RspValid=1 and o_RspY, o_RspF, o_RspErr stable until i_RspReady=1, then go to IDLE; results are only valid in RESP.
REQ-031 SHALL with CACHE_EN=1 keep cached A, B, Op plus a cache-valid bit; a state whose value equals the valid cache entry is skipped (zero cycles).
REQ-032 SHALL set cache-valid after a response with o_RspErr=0, and clear it on reset and on any errored response; LD_F is never skipped.
REQ-033 SHALL give latency, accept edge to o_RspValid: 7 cycles (no UseF, no skips), 8 with UseF, minimum 4 with all three loads skipped and no UseF.
REQ-034 SHALL ignore i_ReqValid outside IDLE; back-to-back acceptance is possible in the cycle after RESP handshake (IDLE cycle).

Reset
REQ-035 SHALL on i_Reset=1 at a clock edge, from any state including mid-sequence, go to IDLE and clear cache-valid and all result registers.
REQ-036 SHALL hold reset values: o_ReqReady=1 (IDLE), o_RspValid=0, o_RspY=0, o_RspF=0, o_RspErr=0, o_Command=COM_NOP, o_BusValid=0, o_BusData=0.

Verification
REQ-037 SHALL cover: ADD A=0x0003 B=0x0004 with a behavioural ALU -> commands LATCHA,LATCHB,LATCHOP,COMPUTE,OUTPUTY,OUTPUTF; o_RspY=0x0007 7 cycles after accept.
REQ-038 SHALL cover: ADC A=0xFFFF B=0x0000 UseF F=carry -> LATCHF issued; o_RspY=0x0000, carry and zero set, latency 8.
REQ-039 SHALL cover: repeat of identical ADD after a clean response -> no LATCHA/B/OP issued; o_RspY=0x0007 after 4 cycles; a change of B alone issues only LATCHB.
REQ-040 SHALL cover: i_BusValid forced 0 during OUTPUTY -> o_RspErr=1, o_RspY=0; next identical request reloads all operands.
REQ-041 SHALL cover: i_RspReady held 0 for 5 cycles -> response stable and o_ReqReady=0 throughout; i_Reset asserted in COMPUTE -> IDLE next cycle with COM_NOP and all outputs at reset values.

Source files
------------

// File: rtl/alu_sequencer.sv
// Command encodings for the ALU bus, followed by the sequencer that loads operands,
// runs the compute step, reads back Y/F and returns them over a valid/ready response.
package constants_pkg;
    localparam int unsigned COM_W = 4;
    localparam logic [COM_W-1:0] COM_NOP     = 4'd0;
    localparam logic [COM_W-1:0] COM_LATCHA  = 4'd1;
    localparam logic [COM_W-1:0] COM_LATCHB  = 4'd2;
    localparam logic [COM_W-1:0] COM_LATCHOP = 4'd3;
    localparam logic [COM_W-1:0] COM_LATCHF  = 4'd4;
    localparam logic [COM_W-1:0] COM_COMPUTE = 4'd5;
    localparam logic [COM_W-1:0] COM_OUTPUTY = 4'd6;
    localparam logic [COM_W-1:0] COM_OUTPUTF = 4'd7;
endpackage

module alu_sequencer #(
    parameter int unsigned WORDSIZE = 16,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic                           i_Clk,
    input  logic                           i_Reset,
    input  logic                           i_ReqValid,
    output logic                           o_ReqReady,
    input  logic [WORDSIZE-1:0]            i_ReqA,
    input  logic [WORDSIZE-1:0]            i_ReqB,
    input  logic [3:0]                     i_ReqOp,
    input  logic                           i_ReqUseF,
    input  logic [WORDSIZE-1:0]            i_ReqF,
    output logic                           o_RspValid,
    input  logic                           i_RspReady,
    output logic [WORDSIZE-1:0]            o_RspY,
    output logic [WORDSIZE-1:0]            o_RspF,
    output logic                           o_RspErr,
    output logic [constants_pkg::COM_W-1:0] o_Command,
    output logic [WORDSIZE-1:0]            o_BusData,
    output logic                           o_BusValid,
    input  logic [WORDSIZE-1:0]            i_BusData,
    input  logic                           i_BusValid
);
    import constants_pkg::*;

    typedef enum logic [3:0] {
        IDLE, LD_A, LD_B, LD_OP, LD_F, COMPUTE, RD_Y, RD_F, RESP
    } state_t;

    state_t               r_State, w_Next;
    logic [WORDSIZE-1:0]  r_A, r_B, r_F, r_Y, r_RF;
    logic [3:0]           r_Op;
    logic                 r_UseF, r_Err;
    logic [WORDSIZE-1:0]  r_CacheA, r_CacheB;
    logic [3:0]           r_CacheOp;
    logic                 r_CacheValid;

    logic                 w_Accept;
    logic                 w_InHitA, w_InHitB, w_InHitOp;
    logic                 w_RegHitA, w_RegHitB, w_RegHitOp;
    logic [COM_W-1:0]     w_Command;
    logic [WORDSIZE-1:0]  w_BusData;
    logic                 w_BusValid;

    // First load state at or after position i_Pos (0=A, 1=B, 2=Op) that the cache cannot skip.
    function automatic state_t f_NextLoad(input logic [1:0] i_Pos, input logic i_HitA,
                                          input logic i_HitB, input logic i_HitOp,
                                          input logic i_UseF);
        if (i_Pos == 2'd0 && !i_HitA)  return LD_A;
        if (i_Pos <= 2'd1 && !i_HitB)  return LD_B;
        if (i_Pos <= 2'd2 && !i_HitOp) return LD_OP;
        if (i_UseF)                    return LD_F;
        return COMPUTE;
    endfunction

    assign w_Accept   = (r_State == IDLE) && i_ReqValid;
    assign w_InHitA   = CACHE_EN && r_CacheValid && (i_ReqA  == r_CacheA);
    assign w_InHitB   = CACHE_EN && r_CacheValid && (i_ReqB  == r_CacheB);
    assign w_InHitOp  = CACHE_EN && r_CacheValid && (i_ReqOp == r_CacheOp);
    assign w_RegHitA  = CACHE_EN && r_CacheValid && (r_A  == r_CacheA);
    assign w_RegHitB  = CACHE_EN && r_CacheValid && (r_B  == r_CacheB);
    assign w_RegHitOp = CACHE_EN && r_CacheValid && (r_Op == r_CacheOp);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State      <= IDLE;
            r_CacheValid <= 1'b0;
            r_Y          <= '0;
            r_RF         <= '0;
            r_Err        <= 1'b0;
        end else begin
            r_State <= w_Next;
            if (w_Accept) begin
                r_A    <= i_ReqA;
                r_B    <= i_ReqB;
                r_Op   <= i_ReqOp;
                r_UseF <= i_ReqUseF;
                r_F    <= i_ReqF;
                r_Err  <= 1'b0;
            end
            if (r_State == RD_Y) begin
                r_Y <= i_BusValid ? i_BusData : '0;
                if (!i_BusValid) r_Err <= 1'b1;
            end
            if (r_State == RD_F) begin
                r_RF <= i_BusValid ? i_BusData : '0;
                if (!i_BusValid) r_Err <= 1'b1;
            end
            // The ALU's latches are only trusted after a clean readback.
            if (r_State == RESP && i_RspReady) begin
                r_CacheValid <= !r_Err;
                r_CacheA     <= r_A;
                r_CacheB     <= r_B;
                r_CacheOp    <= r_Op;
            end
        end
    end

    always_comb begin
        w_Next     = r_State;
        w_Command  = COM_NOP;
        w_BusValid = 1'b0;
        w_BusData  = '0;
        unique case (r_State)
            IDLE: if (i_ReqValid)
                      w_Next = f_NextLoad(2'd0, w_InHitA, w_InHitB, w_InHitOp, i_ReqUseF);
            LD_A: begin
                w_Command  = COM_LATCHA;
                w_BusValid = 1'b1;
                w_BusData  = r_A;
                w_Next     = f_NextLoad(2'd1, w_RegHitA, w_RegHitB, w_RegHitOp, r_UseF);
            end
            LD_B: begin
                w_Command  = COM_LATCHB;
                w_BusValid = 1'b1;
                w_BusData  = r_B;
                w_Next     = f_NextLoad(2'd2, w_RegHitA, w_RegHitB, w_RegHitOp, r_UseF);
            end
            LD_OP: begin
                w_Command  = COM_LATCHOP;
                w_BusValid = 1'b1;
                w_BusData  = {{(WORDSIZE-4){1'b0}}, r_Op};
                w_Next     = f_NextLoad(2'd3, w_RegHitA, w_RegHitB, w_RegHitOp, r_UseF);
            end
            LD_F: begin
                w_Command  = COM_LATCHF;
                w_BusValid = 1'b1;
                w_BusData  = r_F;
                w_Next     = COMPUTE;
            end
            COMPUTE: begin
                w_Command = COM_COMPUTE;
                w_Next    = RD_Y;
            end
            RD_Y: begin
                w_Command = COM_OUTPUTY;
                w_Next    = RD_F;
            end
            RD_F: begin
                w_Command = COM_OUTPUTF;
                w_Next    = RESP;
            end
            RESP: if (i_RspReady) w_Next = IDLE;
            default: w_Next = IDLE;
        endcase
    end

    assign o_ReqReady = (r_State == IDLE);
    assign o_RspValid = (r_State == RESP);
    assign o_RspY     = (r_State == RESP) ? r_Y  : '0;
    assign o_RspF     = (r_State == RESP) ? r_RF : '0;
    assign o_RspErr   = (r_State == RESP) && r_Err;
    assign o_Command  = w_Command;
    assign o_BusData  = w_BusData;
    assign o_BusValid = w_BusValid;
endmodule
